secded_dec_engine: RTL

//  Hardware SECDED (Hamming 16,11) decode engine; the program-2 stage in hardware form.

---
 rtl/secded_dec_engine_if.sv | 24 ++
 rtl/secded_dec_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/secded_dec_engine_if.sv
// Start/done handshake plus the byte-wide data-memory port of the SECDED decode engine.
// master: the engine. slave: the environment (controller and data memory).
interface secded_dec_engine_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rdata;
  logic              mem_wr_en;
  logic [7:0]        mem_wdata;

  modport master (
    input  start, mem_rdata,
    output done, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport slave (
    output start, mem_rdata,
    input  done, busy, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/secded_dec_engine.sv
// SECDED (Hamming 16,11) decode engine. Reads NUM_WORDS encoded words from SRC_BASE,
// corrects single errors, flags double errors and writes one result word per input to
// DST_BASE. Result word: {flags[1:0], 3'b000, d[11:1]}.
// Optional feature macro SECDED_STATS_EN: adds saturating sgl_cnt/dbl_cnt outputs.
module secded_dec_engine #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0
) (
  input logic                 clk,
  input logic                 reset,
  secded_dec_engine_if.master bus
`ifdef SECDED_STATS_EN
  ,
  output logic [3:0]          sgl_cnt,
  output logic [3:0]          dbl_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle, StRdLo, StRdHi, StCap, StDec, StWrLo, StWrHi, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [15:0]       word_q, res_q, res_d;
  logic              done_q, busy_q;
  logic [ADDR_W-1:0] off, src_lo, dst_lo;
  logic [ADDR_W-1:0] addr;
  logic              rd_en, wr_en;
  logic [7:0]        wdata;

  logic              s8, s4, s2, s1, pa;
  logic [3:0]        syn;
  logic [1:0]        flags;
  logic [15:0]       wc;
  logic              unused_wc;

  // Word i sits 2i bytes from its base; sums wrap modulo 2^ADDR_W.
  assign off    = ADDR_W'(idx_q) << 1;
  assign src_lo = ADDR_W'(SRC_BASE) + off;
  assign dst_lo = ADDR_W'(DST_BASE) + off;

  assign s8  = ^word_q[15:8];
  assign s4  = ^{word_q[15:12], word_q[7:4]};
  assign s2  = ^{word_q[15], word_q[14], word_q[11], word_q[10],
                 word_q[7], word_q[6], word_q[3], word_q[2]};
  assign s1  = ^{word_q[15], word_q[13], word_q[11], word_q[9],
                 word_q[7], word_q[5], word_q[3], word_q[1]};
  assign pa  = ^word_q;
  assign syn = {s8, s4, s2, s1};

  // Decode: odd overall parity means a single error at bit position syn (0 = p0).
  always_comb begin
    wc    = word_q;
    flags = 2'b00;
    if (pa) begin
      flags = 2'b01;
      wc    = word_q ^ (16'h0001 << syn);
    end else if (syn != 4'd0) begin
      flags = 2'b10;
    end
    res_d = {flags, 3'b000, wc[15:9], wc[7:5], wc[3]};
  end

  // Parity positions of the corrected word carry no result data.
  assign unused_wc = ^{wc[8], wc[4], wc[2:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: six states per word, then one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRdLo;
      StRdLo:  state_d = StRdHi;
      StRdHi:  state_d = StCap;
      StCap:   state_d = StDec;
      StDec:   state_d = StWrLo;
      StWrLo:  state_d = StWrHi;
      StWrHi:  state_d = (idx_q == LastIdx) ? StDone : StRdLo;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory strobes, address and write data decoded from the current state.
  always_comb begin
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = '0;
    wdata = '0;
    case (state_q)
      StRdLo: begin
        rd_en = 1'b1;
        addr  = src_lo;
      end
      StRdHi: begin
        rd_en = 1'b1;
        addr  = src_lo + ADDR_W'(1);
      end
      StWrLo: begin
        wr_en = 1'b1;
        addr  = dst_lo;
        wdata = res_q[7:0];
      end
      StWrHi: begin
        wr_en = 1'b1;
        addr  = dst_lo + ADDR_W'(1);
        wdata = res_q[15:8];
      end
      default: ;
    endcase
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

  // Datapath: word index, captured code word, registered result and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q  <= '0;
      word_q <= '0;
      res_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            idx_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        StRdHi:  word_q[7:0]  <= bus.mem_rdata;
        StCap:   word_q[15:8] <= bus.mem_rdata;
        StDec:   res_q        <= res_d;
        StWrHi:  if (idx_q != LastIdx) idx_q <= idx_q + IDX_W'(1);
        StDone: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SECDED_STATS_EN
  // Per-run error statistics, cleared on an accepted start, saturating at 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (state_q == StIdle && bus.start) begin
      sgl_cnt <= '0;
      dbl_cnt <= '0;
    end else if (state_q == StDec) begin
      if (flags == 2'b01 && sgl_cnt != 4'hF) sgl_cnt <= sgl_cnt + 4'd1;
      if (flags[1] && dbl_cnt != 4'hF) dbl_cnt <= dbl_cnt + 4'd1;
    end
  end
`endif

endmodule
